// File: rtl/axi_sram_pkg.sv
// Shared encodings, FSM states and address-advance helper for the AXI4 SRAM slave.
package axi_sram_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_e;

    // Byte address of the next beat; WRAP folds back inside the (len+1)<<size window.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst,
                                              input logic        wrap_en);
        logic [31:0] step;
        logic [31:0] span;
        logic [31:0] bumped;
        step   = 32'd1 << size;
        span   = ({24'd0, len} + 32'd1) << size;
        bumped = addr + step;
        next_addr = bumped;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if (burst == BURST_WRAP && wrap_en) begin
            next_addr = (addr & ~(span - 32'd1)) | (bumped & (span - 32'd1));
        end
    endfunction

endpackage

// File: rtl/sram_dp.sv
// Simple dual-port SRAM: byte-enable write port, registered read port with enable.
module sram_dp #(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW/8-1:0]   wstrb,
    input  logic [DW-1:0]     wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] ram [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (wstrb[b]) begin
                    ram[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Same-cycle read of a word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= ram[raddr];
        end
    end

endmodule

// File: rtl/axi_full_slave_sram.sv
// AXI4 slave with independent read/write burst engines over an on-chip SRAM.
// Define AXI_SRAM_WRAP_EN to honour WRAP bursts; otherwise WRAP behaves as INCR.
module axi_full_slave_sram
    import axi_sram_pkg::*;
#(
    parameter int unsigned DW = 128,
    parameter int unsigned AW = 14,
    parameter int unsigned IW = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [IW-1:0]     MEM_AWID,
    input  logic [31:0]       MEM_AWADDR,
    input  logic [7:0]        MEM_AWLEN,
    input  logic [2:0]        MEM_AWSIZE,
    input  logic [1:0]        MEM_AWBURST,
    input  logic              MEM_AWVALID,
    output logic              MEM_AWREADY,
    input  logic [DW-1:0]     MEM_WDATA,
    input  logic [DW/8-1:0]   MEM_WSTRB,
    input  logic              MEM_WLAST,
    input  logic              MEM_WVALID,
    output logic              MEM_WREADY,
    output logic [IW-1:0]     MEM_BID,
    output logic [1:0]        MEM_BRESP,
    output logic              MEM_BVALID,
    input  logic              MEM_BREADY,
    input  logic [IW-1:0]     MEM_ARID,
    input  logic [31:0]       MEM_ARADDR,
    input  logic [7:0]        MEM_ARLEN,
    input  logic [2:0]        MEM_ARSIZE,
    input  logic [1:0]        MEM_ARBURST,
    input  logic              MEM_ARVALID,
    output logic              MEM_ARREADY,
    output logic [IW-1:0]     MEM_RID,
    output logic [DW-1:0]     MEM_RDATA,
    output logic [1:0]        MEM_RRESP,
    output logic              MEM_RLAST,
    output logic              MEM_RVALID,
    input  logic              MEM_RREADY
);

    localparam int unsigned OW = $clog2(DW / 8);
`ifdef AXI_SRAM_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    // Write engine
    wr_state_e     w_state, w_state_next;
    logic [IW-1:0] w_id;
    logic [31:0]   w_addr;
    logic [7:0]    w_len, w_cnt;
    logic [2:0]    w_size;
    logic [1:0]    w_burst;
    logic          w_hs, w_last;

    assign w_hs   = MEM_WVALID && (w_state == W_DATA);
    assign w_last = MEM_WLAST || (w_cnt == w_len);

    always_comb begin
        w_state_next = w_state;
        MEM_AWREADY  = 1'b0;
        MEM_WREADY   = 1'b0;
        MEM_BVALID   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                MEM_AWREADY = 1'b1;
                if (MEM_AWVALID) w_state_next = W_DATA;
            end
            W_DATA: begin
                MEM_WREADY = 1'b1;
                if (MEM_WVALID && w_last) w_state_next = W_RESP;
            end
            W_RESP: begin
                MEM_BVALID = 1'b1;
                if (MEM_BREADY) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
        end else begin
            w_state <= w_state_next;
            if (MEM_AWVALID && w_state == W_IDLE) begin
                w_id    <= MEM_AWID;
                w_addr  <= MEM_AWADDR;
                w_len   <= MEM_AWLEN;
                w_size  <= MEM_AWSIZE;
                w_burst <= MEM_AWBURST;
                w_cnt   <= '0;
            end else if (w_hs) begin
                w_addr <= next_addr(w_addr, w_len, w_size, w_burst, WRAP_EN);
                w_cnt  <= w_cnt + 8'd1;
            end
        end
    end

    assign MEM_BID   = w_id;
    assign MEM_BRESP = RESP_OKAY;

    // Read engine: beats are issued into the SRAM read register whenever the output slot frees up
    rd_state_e     r_state, r_state_next;
    logic [IW-1:0] r_id;
    logic [31:0]   r_addr;
    logic [7:0]    r_len;
    logic [8:0]    r_cnt;
    logic [2:0]    r_size;
    logic [1:0]    r_burst;
    logic          r_valid, r_last;
    logic          r_issue;

    assign r_issue = (r_state == R_DATA) && ({1'b0, r_len} >= r_cnt) && (!r_valid || MEM_RREADY);

    always_comb begin
        r_state_next = r_state;
        MEM_ARREADY  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                MEM_ARREADY = 1'b1;
                if (MEM_ARVALID) r_state_next = R_DATA;
            end
            R_DATA: begin
                if (r_valid && r_last && MEM_RREADY) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= r_state_next;
            if (MEM_ARVALID && r_state == R_IDLE) begin
                r_id    <= MEM_ARID;
                r_addr  <= MEM_ARADDR;
                r_len   <= MEM_ARLEN;
                r_size  <= MEM_ARSIZE;
                r_burst <= MEM_ARBURST;
                r_cnt   <= '0;
            end
            if (r_issue) begin
                r_valid <= 1'b1;
                r_last  <= ({1'b0, r_len} == r_cnt);
                r_addr  <= next_addr(r_addr, r_len, r_size, r_burst, WRAP_EN);
                r_cnt   <= r_cnt + 9'd1;
            end else if (r_valid && MEM_RREADY) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign MEM_RID    = r_id;
    assign MEM_RVALID = r_valid;
    assign MEM_RLAST  = r_last;
    assign MEM_RRESP  = RESP_OKAY;

    sram_dp #(
        .DW (DW),
        .AW (AW)
    ) i_sram (
        .clk   (CLK),
        .we    (w_hs && RSTn),
        .waddr (w_addr[AW+OW-1:OW]),
        .wstrb (MEM_WSTRB),
        .wdata (MEM_WDATA),
        .re    (r_issue && RSTn),
        .raddr (r_addr[AW+OW-1:OW]),
        .rdata (MEM_RDATA)
    );

endmodule

// File: tb/tb_axi_full_slave_sram.sv
// Self-checking bench for axi_full_slave_sram: address-sequence table, directed corners,
// and randomized bursts against a word-array memory model.
`timescale 1ns/1ps
module tb_axi_full_slave_sram;

    localparam int DW = 128;
    localparam int AW = 14;
    localparam int IW = 8;
    localparam int NW = 1 << AW;
`ifdef AXI_SRAM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic [IW-1:0] MEM_AWID = '0, MEM_ARID = '0;
    logic [31:0] MEM_AWADDR = '0, MEM_ARADDR = '0;
    logic [7:0] MEM_AWLEN = '0, MEM_ARLEN = '0;
    logic [2:0] MEM_AWSIZE = '0, MEM_ARSIZE = '0;
    logic [1:0] MEM_AWBURST = '0, MEM_ARBURST = '0;
    logic MEM_AWVALID = 1'b0, MEM_ARVALID = 1'b0;
    logic MEM_AWREADY, MEM_ARREADY;
    logic [DW-1:0] MEM_WDATA = '0;
    logic [DW/8-1:0] MEM_WSTRB = '0;
    logic MEM_WLAST = 1'b0, MEM_WVALID = 1'b0, MEM_WREADY;
    logic [IW-1:0] MEM_BID, MEM_RID;
    logic [1:0] MEM_BRESP, MEM_RRESP;
    logic MEM_BVALID, MEM_BREADY = 1'b0;
    logic [DW-1:0] MEM_RDATA;
    logic MEM_RLAST, MEM_RVALID, MEM_RREADY = 1'b0;

    always #5 CLK = ~CLK;

    axi_full_slave_sram #(.DW(DW), .AW(AW), .IW(IW)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
        .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID),
        .MEM_AWREADY(MEM_AWREADY),
        .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
        .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
        .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID),
        .MEM_BREADY(MEM_BREADY),
        .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
        .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID),
        .MEM_ARREADY(MEM_ARREADY),
        .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP),
        .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
    );

    logic [DW-1:0]   mem_m [NW];
    logic [DW-1:0]   wd [256];
    logic [DW/8-1:0] ws [256];
    int unsigned     rd_words [256];
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          size;
        logic [1:0]  burst;
        logic [7:0]  id;
        int          words [4];
        string       name;
    } vec_t;
    vec_t vq [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic expired(input string name);
        n_checks++;
        $display("FAIL %s: actual timeout required handshake", name);
    endtask

    function automatic logic [127:0] pat(input int unsigned i);
        return {8'hA5, i[23:0], i * 32'h9E3779B9, 32'hDEADBEEF ^ i, ~i};
    endfunction

    // Word touched by beat i, from the closed-form AXI address rules.
    function automatic int unsigned beat_word(input logic [31:0] start, input int len,
                                              input int size, input logic [1:0] burst,
                                              input int i);
        longint unsigned nb, wb, base, a, s;
        s  = longint'(start);
        nb = 64'd1 << size;
        if (burst == 2'b00) begin
            a = s;
        end else if (burst == 2'b10 && WRAP_EN) begin
            wb   = longint'(len + 1) * nb;
            base = s - (s % wb);
            a    = base + ((s - base + longint'(i) * nb) % wb);
        end else begin
            a = s + longint'(i) * nb;
        end
        return int'((a >> 4) % NW);
    endfunction

    task automatic bd_write(input int unsigned w, input logic [DW-1:0] v);
        dut.i_sram.ram[w] = v;
        mem_m[w] = v;
    endtask

    task automatic add_vec(input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input logic [7:0] id, input int w0,
                           input int w1, input int w2, input int w3, input string name);
        vec_t v;
        v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
        v.words[0] = w0; v.words[1] = w1; v.words[2] = w2; v.words[3] = w3;
        v.name = name;
        vq.push_back(v);
    endtask

    task automatic axi_write(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                             input int size, input logic [1:0] burst, input int nbeats,
                             input bit gaps, input string tag);
        int n;
        int unsigned w;
        @(negedge CLK);
        MEM_AWVALID = 1'b1; MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = 8'(len);
        MEM_AWSIZE = 3'(size); MEM_AWBURST = burst;
        n = 0;
        while (!MEM_AWREADY && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) begin expired({tag, " aw"}); MEM_AWVALID = 1'b0; return; end
        @(negedge CLK);
        MEM_AWVALID = 1'b0;
        check({tag, " awready_drop"}, 128'(MEM_AWREADY), 128'(0));
        check({tag, " wready_rise"}, 128'(MEM_WREADY), 128'(1));
        for (int i = 0; i < nbeats; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                MEM_WVALID = 1'b0;
                @(negedge CLK);
            end
            MEM_WVALID = 1'b1; MEM_WDATA = wd[i]; MEM_WSTRB = ws[i];
            MEM_WLAST = (i == nbeats - 1);
            n = 0;
            while (!MEM_WREADY && n < 200) begin @(negedge CLK); n++; end
            if (n >= 200) begin expired({tag, " w"}); MEM_WVALID = 1'b0; return; end
            w = beat_word(addr, len, size, burst, i);
            for (int b = 0; b < DW / 8; b++)
                if (ws[i][b]) mem_m[w][8*b +: 8] = wd[i][8*b +: 8];
            @(negedge CLK);
        end
        MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
        check({tag, " bvalid_rise"}, 128'(MEM_BVALID), 128'(1));
        check({tag, " bid"}, 128'(MEM_BID), 128'(id));
        check({tag, " bresp"}, 128'(MEM_BRESP), 128'(0));
        MEM_BREADY = 1'b1;
        @(negedge CLK);
        MEM_BREADY = 1'b0;
        check({tag, " idle_after_b"}, {126'd0, MEM_BVALID, MEM_AWREADY}, 128'(1));
    endtask

    // mode: 0 RREADY held high, 1 toggling 1,0,1,0, 2 random
    task automatic axi_read(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                            input int size, input logic [1:0] burst, input int mode,
                            input string tag);
        logic [DW-1:0] exp [256];
        int n, beat, k;
        for (int i = 0; i <= len; i++) exp[i] = mem_m[rd_words[i]];
        @(negedge CLK);
        MEM_ARVALID = 1'b1; MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = 8'(len);
        MEM_ARSIZE = 3'(size); MEM_ARBURST = burst;
        n = 0;
        while (!MEM_ARREADY && n < 200) begin @(negedge CLK); n++; end
        if (n >= 200) begin expired({tag, " ar"}); MEM_ARVALID = 1'b0; return; end
        @(negedge CLK);
        MEM_ARVALID = 1'b0;
        check({tag, " arready_drop"}, 128'(MEM_ARREADY), 128'(0));
        check({tag, " rvalid_lat1"}, 128'(MEM_RVALID), 128'(0));
        @(negedge CLK);
        check({tag, " rvalid_lat2"}, 128'(MEM_RVALID), 128'(1));
        beat = 0; k = 0; n = 0;
        while (beat <= len && n < 2000) begin
            MEM_RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            k++;
            if (MEM_RVALID) begin
                check($sformatf("%s rdata[%0d]", tag, beat), MEM_RDATA, exp[beat]);
                check($sformatf("%s rlast[%0d]", tag, beat), 128'(MEM_RLAST), 128'(beat == len));
                check($sformatf("%s rid[%0d]", tag, beat), 128'(MEM_RID), 128'(id));
                check($sformatf("%s rresp[%0d]", tag, beat), 128'(MEM_RRESP), 128'(0));
                if (MEM_RREADY) beat++;
            end
            @(negedge CLK);
            n++;
        end
        MEM_RREADY = 1'b0;
        if (beat <= len) begin expired({tag, " r"}); return; end
        check({tag, " idle_after_r"}, {126'd0, MEM_RVALID, MEM_ARREADY}, 128'(1));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual still running required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w;
        logic [127:0] v;
        int len, size, op;
        logic [1:0] burst;
        logic [31:0] addr;
        bit saw;

        for (int i = 0; i < 256; i++) bd_write(i, pat(i));
        bd_write(0, 128'h0F0E0D0C0B0A09080706050403020100);

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst awready", 128'(MEM_AWREADY), 128'(1));
        check("rst arready", 128'(MEM_ARREADY), 128'(1));
        check("rst wready", 128'(MEM_WREADY), 128'(0));
        check("rst bvalid", 128'(MEM_BVALID), 128'(0));
        check("rst rvalid", 128'(MEM_RVALID), 128'(0));
        check("rst rlast", 128'(MEM_RLAST), 128'(0));
        check("rst resp", {124'd0, MEM_BRESP, MEM_RRESP}, 128'(0));
        check("rst ids", {112'd0, MEM_BID, MEM_RID}, 128'(0));
        RSTn = 1'b1;

        // Address-sequence table: expected words derived by hand
        add_vec(32'h8000_0000, 0, 4, 2'b01, 8'h11, 0, 0, 0, 0, "alias0");
        add_vec(32'h0000_0010, 3, 4, 2'b01, 8'h22, 1, 2, 3, 4, "incr4");
`ifdef AXI_SRAM_WRAP_EN
        add_vec(32'h0000_0030, 3, 4, 2'b10, 8'h33, 3, 0, 1, 2, "wrap4");
        add_vec(32'h0000_0028, 3, 3, 2'b10, 8'h66, 2, 3, 3, 2, "wrap_narrow");
        add_vec(32'h0000_0090, 1, 4, 2'b10, 8'h88, 9, 8, 0, 0, "wrap2");
`else
        add_vec(32'h0000_0030, 3, 4, 2'b10, 8'h33, 3, 4, 5, 6, "wrap4");
        add_vec(32'h0000_0028, 3, 3, 2'b10, 8'h66, 2, 3, 3, 4, "wrap_narrow");
        add_vec(32'h0000_0090, 1, 4, 2'b10, 8'h88, 9, 10, 0, 0, "wrap2");
`endif
        add_vec(32'h0000_0050, 3, 4, 2'b00, 8'h44, 5, 5, 5, 5, "fixed");
        add_vec(32'h0000_0008, 3, 3, 2'b01, 8'h55, 0, 1, 1, 2, "incr_narrow");
        add_vec(32'h0004_0070, 1, 4, 2'b01, 8'h77, 7, 8, 0, 0, "alias_hi");
        foreach (vq[t]) begin
            for (int i = 0; i <= vq[t].len; i++) rd_words[i] = vq[t].words[i];
            axi_read(vq[t].id, vq[t].addr, vq[t].len, vq[t].size, vq[t].burst, 0, vq[t].name);
        end

        // INCR write of 1..4 then readback
        for (int i = 0; i < 4; i++) begin wd[i] = 128'(i + 1); ws[i] = '1; end
        axi_write(8'h3C, 32'h10, 3, 4, 2'b01, 4, 1'b0, "wr_incr");
        for (int i = 1; i <= 4; i++)
            check($sformatf("wr_incr ram[%0d]", i), dut.i_sram.ram[i], 128'(i));
        for (int i = 0; i < 4; i++) rd_words[i] = beat_word(32'h10, 3, 4, 2'b01, i);
        axi_read(8'hC3, 32'h10, 3, 4, 2'b01, 0, "rd_back");

        // Single-byte strobe
        wd[0] = 128'hAB; ws[0] = 16'h0001;
        axi_write(8'h05, 32'h50, 0, 4, 2'b01, 1, 1'b0, "wr_strb");
        v = pat(5);
        check("wr_strb ram[5]", dut.i_sram.ram[5], {v[127:8], 8'hAB});

        // Backpressure: RREADY toggling over an 8-beat burst
        for (int i = 0; i < 8; i++) rd_words[i] = 8 + i;
        axi_read(8'h9A, 32'h80, 7, 4, 2'b01, 1, "rd_toggle");

        // Early WLAST ends a len-3 burst after two beats
        for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = '1; end
        axi_write(8'h61, 32'h600, 3, 4, 2'b01, 2, 1'b0, "wr_early");
        check("wr_early ram[97]", dut.i_sram.ram[97], wd[1]);
        check("wr_early ram[98]", dut.i_sram.ram[98], pat(98));

        // Concurrent write and read bursts
        for (int i = 0; i < 8; i++) begin
            wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'($urandom);
            rd_words[i] = 100 + i;
        end
        fork
            axi_write(8'h40, 32'h280, 7, 4, 2'b01, 8, 1'b1, "cc_wr");
            axi_read(8'h41, 32'h640, 7, 4, 2'b01, 2, "cc_rd");
        join
        for (int i = 0; i < 8; i++) rd_words[i] = 40 + i;
        axi_read(8'h42, 32'h280, 7, 4, 2'b01, 0, "cc_back");

        // Reset mid-read aborts the burst
        @(negedge CLK);
        MEM_ARVALID = 1'b1; MEM_ARID = 8'h5A; MEM_ARADDR = 32'h0; MEM_ARLEN = 8'd7;
        MEM_ARSIZE = 3'd4; MEM_ARBURST = 2'b01;
        @(negedge CLK);
        MEM_ARVALID = 1'b0; MEM_RREADY = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_mid rvalid_before", 128'(MEM_RVALID), 128'(1));
        RSTn = 1'b0;
        @(negedge CLK);
        check("rst_mid rvalid", 128'(MEM_RVALID), 128'(0));
        check("rst_mid arready", 128'(MEM_ARREADY), 128'(1));
        RSTn = 1'b1;
        saw = 1'b0;
        repeat (6) begin @(negedge CLK); if (MEM_RVALID) saw = 1'b1; end
        check("rst_mid no_more_beats", 128'(saw), 128'(0));
        MEM_RREADY = 1'b0;

        // Randomized bursts against the model
        for (int t = 0; t < 30; t++) begin
            op    = $urandom_range(0, 1);
            size  = $urandom_range(0, 4);
            burst = 2'($urandom_range(0, 2));
            if (burst == 2'b10) len = (2 << $urandom_range(0, 3)) - 1;
            else len = $urandom_range(0, 15);
            w = $urandom_range(0, 180);
            addr = ($urandom & 32'hFFFC_0000) | (w << 4)
                 | (32'($urandom_range(0, 15)) & ~((32'd1 << size) - 1));
            if (op == 0) begin
                for (int i = 0; i <= len; i++) begin
                    wd[i] = {$urandom, $urandom, $urandom, $urandom}; ws[i] = 16'($urandom);
                end
                axi_write(8'($urandom), addr, len, size, burst, len + 1, 1'b1,
                          $sformatf("rnd%0d_wr", t));
            end else begin
                for (int i = 0; i <= len; i++) rd_words[i] = beat_word(addr, len, size, burst, i);
                axi_read(8'($urandom), addr, len, size, burst, 2, $sformatf("rnd%0d_rd", t));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
